md5_rounds_1_to_16: RTL and testbench
=====================================

Name: md5_rounds_1_to_16

Overview:
- Computes MD5 round-1 steps 0..15 (F function) over one 512-bit block, starting from a given A/B/C/D chaining state.
- Returns the state after step 15, without the final feed-forward addition.
- Sits inside the MD5 compression datapath, ahead of the round-2..4 blocks.
- Baseline: iterative, one step per clock, with valid/ready handshakes on input and output.

Parameters:
- NUM_STEPS, 16, steps performed per block. Fixed at 16; any other value is unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  a_in..d_in and message are valid.
- in_ready  output  1  block can accept a new job.
- a_in  input  32  chaining word A.
- b_in  input  32  chaining word B.
- c_in  input  32  chaining word C.
- d_in  input  32  chaining word D.
- message  input  512  16 little-endian-interpreted words; word j = message[32j+31:32j].
- out_valid  output  1  a_out..d_out hold a result.
- out_ready  input  1  consumer accepts the result.
- a_out  output  32  A after step 15.
- b_out  output  32  B after step 15.
- c_out  output  32  C after step 15.
- d_out  output  32  D after step 15.

Behaviour:
- Reset (async, rst_n=0):
  - FSM returns to IDLE.
  - in_ready=1, out_valid=0.
  - a_out..d_out=0, step counter=0, internal A..D=0.
  - A reset mid-operation aborts the job; no output is produced.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a_in..d_in and all 16 message words; go to RUN with step=0.
  - RUN: in_ready=0. One step per cycle, steps i=0..15. After step 15 is registered, go to DONE.
  - DONE: out_valid=1, outputs stable. On out_ready, go to IDLE.
- Latency: accept edge, then 16 RUN cycles; out_valid rises on the 16th edge after acceptance.
- Inputs may change freely after acceptance; they are latched.
- Step i (all arithmetic mod 2^32):
  - F = (B & C) | (~B & D)
  - T = A + F + K[i] + M[i]
  - newB = B + rotl(T, s[i])
  - Then (A,B,C,D) <= (D, newB, B, C).
- Shift schedule: s[i] = 7, 12, 17, 22, repeating by i mod 4.
- K[i] = floor(|sin(i+1)| * 2^32) for i=0..15: d76aa478 e8c7b756 242070db c1bdceee f57c0faf 4787c62a a8304613 fd469501 698098d8 8b44f7af ffff5bb1 895cd7be 6b901122 fd987193 a679438e 49b40821.
- No endianness swap inside the block; words are used as given.
- in_valid while busy is ignored. Holding out_ready=1 in DONE returns to IDLE the next cycle. A new input can be accepted only once back in IDLE.

Optional Feature:
- Macro MD5_R1_UNROLL_EN.
- Defined:
  - All 16 steps are instantiated as a combinational chain between an input register stage and the output register.
  - A result enters DONE one edge after acceptance (latency 1).
  - in_ready = !out_valid || out_ready.
- Undefined: iterative 16-cycle datapath as above.
- Output values are identical either way.

Decomposition:
- Package md5_pkg holds:
  - the K[0..63] constant array and the shift table;
  - the F/G/H/I functions and rotl;
  - an FSM state typedef (IDLE, RUN, DONE).
- One sub-module md5_step: combinational single step with inputs A/B/C/D, M, K and shift, and outputs the rotated A/B/C/D. Used once in iterative mode, 16 times when unrolled.

Test Plan:
- Reset: rst_n=0 mid-RUN -> out_valid=0, in_ready=1, outputs 0 immediately (asynchronous).
- Single step, standard IV (67452301 efcdab89 98badcfe 10325476) with M0=6c6c6548 -> after step 0: A=10325476, B=db528b2a, C=efcdab89, D=98badcfe.
- All-zero state and message -> after step 0: B=b5523c6b, A=C=D=0.
- Full run:
  - IV with message words 6c6c6548 4e45206f 30384d50 54202138 20736968 6d207369 444d2079 6d692035 6d656c70 61746e65 6e6f6974 206e6920 69726576 80676f6c 000001b8 00000000.
  - Required: a_out..d_out equal a software MD5 model truncated after step 15, with out_valid exactly 16 cycles after acceptance.
- Handshake: out_ready=0 for 5 cycles -> outputs held, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE, and back-to-back jobs produce correct results.
- Rerun the full-run and handshake scenarios with MD5_R1_UNROLL_EN -> identical values, latency 1.

Source files
------------

// File: rtl/md5_pkg.sv
// MD5 constants, round functions, rotate helper and the block FSM state type
// shared by the round-1 datapath.
package md5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md5_state_e;

  localparam logic [31:0] K_TABLE [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Four shift amounts per round; a step uses entry (round, step mod 4).
  localparam logic [4:0] S_TABLE [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] shift_amt(input logic [5:0] i);
    return S_TABLE[{i[5:4], i[1:0]}];
  endfunction

  function automatic logic [31:0] f_fn(input logic [31:0] x, y, z);
    return (x & y) | (~x & z);
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] x, y, z);
    return (x & z) | (y & ~z);
  endfunction

  function automatic logic [31:0] h_fn(input logic [31:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [31:0] i_fn(input logic [31:0] x, y, z);
    return y ^ (x | ~z);
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] dbl;
    dbl = {x, x} << s;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/md5_rounds_1_to_16_if.sv
// Job/result handshake bundle for the MD5 round-1 block.
// A transfer happens on a rising edge where valid and ready are both high.
interface md5_rounds_1_to_16_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  a_in;
  logic [31:0]  b_in;
  logic [31:0]  c_in;
  logic [31:0]  d_in;
  logic [511:0] message;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  a_out;
  logic [31:0]  b_out;
  logic [31:0]  c_out;
  logic [31:0]  d_out;

  modport master (
    output in_valid, a_in, b_in, c_in, d_in, message, out_ready,
    input  in_ready, out_valid, a_out, b_out, c_out, d_out
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, d_in, message, out_ready,
    output in_ready, out_valid, a_out, b_out, c_out, d_out
  );
endinterface

// File: rtl/md5_step.sv
// One MD5 round-1 step: F mix, add, rotate, then rotate the A/B/C/D words.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] m,
  input  logic [31:0] k,
  input  logic [4:0]  shift,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);
  logic [31:0] t;

  assign t      = a + f_fn(b, c, d) + k + m;
  assign a_next = d;
  assign b_next = b + rotl(t, shift);
  assign c_next = b;
  assign d_next = c;
endmodule

// File: rtl/md5_rounds_1_to_16.sv
// MD5 round-1 (steps 0..15) without feed-forward. Default build iterates one
// step per clock; defining MD5_R1_UNROLL_EN builds a 16-step combinational chain.
module md5_rounds_1_to_16
  import md5_pkg::*;
#(
  parameter int NUM_STEPS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  md5_rounds_1_to_16_if.slave  bus,
  output md5_state_e           dbg_state
);

`ifdef MD5_R1_UNROLL_EN

  logic         s1_valid;
  logic         out_valid_q;
  logic         in_ready_c;
  logic [31:0]  a_r, b_r, c_r, d_r;
  logic [511:0] msg_r;
  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  ca [NUM_STEPS+1];
  logic [31:0]  cb [NUM_STEPS+1];
  logic [31:0]  cc [NUM_STEPS+1];
  logic [31:0]  cd [NUM_STEPS+1];

  assign ca[0] = a_r;
  assign cb[0] = b_r;
  assign cc[0] = c_r;
  assign cd[0] = d_r;

  for (genvar i = 0; i < NUM_STEPS; i++) begin : g_step
    md5_step u_step (
      .a(ca[i]), .b(cb[i]), .c(cc[i]), .d(cd[i]),
      .m(msg_r[32*i +: 32]), .k(K_TABLE[i]), .shift(shift_amt(6'(i))),
      .a_next(ca[i+1]), .b_next(cb[i+1]), .c_next(cc[i+1]), .d_next(cd[i+1])
    );
  end

  // Input stage drains into the output register whenever the output is free.
  assign in_ready_c = !out_valid_q || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0;
      msg_r <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
    end else if (in_ready_c) begin
      s1_valid    <= bus.in_valid;
      out_valid_q <= s1_valid;
      if (bus.in_valid) begin
        a_r <= bus.a_in; b_r <= bus.b_in; c_r <= bus.c_in; d_r <= bus.d_in;
        msg_r <= bus.message;
      end
      if (s1_valid) begin
        a_q <= ca[NUM_STEPS]; b_q <= cb[NUM_STEPS];
        c_q <= cc[NUM_STEPS]; d_q <= cd[NUM_STEPS];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.c_out     = c_q;
  assign bus.d_out     = d_q;
  assign dbg_state     = out_valid_q ? DONE : (s1_valid ? RUN : IDLE);

`else

  md5_state_e   state, state_next;
  logic [3:0]   step;
  logic [31:0]  a_r, b_r, c_r, d_r;
  logic [511:0] msg_r;
  logic [31:0]  a_s, b_s, c_s, d_s;
  logic         last_step;
  logic         in_ready_c;
  logic         out_valid_c;

  assign last_step = (step == 4'(NUM_STEPS - 1));

  md5_step u_step (
    .a(a_r), .b(b_r), .c(c_r), .d(d_r),
    .m(msg_r[{step, 5'd0} +: 32]), .k(K_TABLE[{2'b00, step}]),
    .shift(shift_amt({2'b00, step})),
    .a_next(a_s), .b_next(b_s), .c_next(c_s), .d_next(d_s)
  );

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN:  if (last_step) state_next = DONE;
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= '0;
      a_r <= '0; b_r <= '0; c_r <= '0; d_r <= '0;
      msg_r <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r <= bus.a_in; b_r <= bus.b_in; c_r <= bus.c_in; d_r <= bus.d_in;
          msg_r <= bus.message;
          step  <= '0;
        end
        RUN: begin
          a_r <= a_s; b_r <= b_s; c_r <= c_s; d_r <= d_s;
          step <= step + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Working registers double as the result; they are frozen outside RUN.
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.c_out     = c_r;
  assign bus.d_out     = d_r;
  assign dbg_state     = state;

`endif

endmodule

// File: tb/tb_md5_rounds_1_to_16.sv
// Directed bench for md5_rounds_1_to_16 in either build (MD5_R1_UNROLL_EN or not).
module tb_md5_rounds_1_to_16;
  import md5_pkg::*;

`ifdef MD5_R1_UNROLL_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 16;
`endif
  localparam int MID_WAIT = (LAT > 1) ? 3 : 0;

  localparam logic [31:0] K_REF [16] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821
  };
  localparam logic [31:0] MSG_W [16] = '{
    32'h6c6c6548, 32'h4e45206f, 32'h30384d50, 32'h54202138,
    32'h20736968, 32'h6d207369, 32'h444d2079, 32'h6d692035,
    32'h6d656c70, 32'h61746e65, 32'h6e6f6974, 32'h206e6920,
    32'h69726576, 32'h80676f6c, 32'h000001b8, 32'h00000000
  };

  logic clk;
  logic rst_n;
  md5_state_e dbg_state;
  int checks = 0;
  int errors = 0;

  md5_rounds_1_to_16_if bus ();

  md5_rounds_1_to_16 dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  logic [31:0] st_a, st_b, st_c, st_d, st_m, st_k;
  logic [4:0]  st_s;
  logic [31:0] st_an, st_bn, st_cn, st_dn;

  md5_step u_ref_step (
    .a(st_a), .b(st_b), .c(st_c), .d(st_d), .m(st_m), .k(st_k), .shift(st_s),
    .a_next(st_an), .b_next(st_bn), .c_next(st_cn), .d_next(st_dn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [31:0] a, b, c, d,
                                         input logic [511:0] msg);
    logic [31:0] f, t, tmp;
    int s;
    for (int i = 0; i < 16; i++) begin
      f = (b & c) | (~b & d);
      t = a + f + K_REF[i] + msg[32*i +: 32];
      s = 7 + 5 * (i % 4);
      tmp = d;
      d = c;
      c = b;
      b = b + ((t << s) | (t >> (32 - s)));
      a = tmp;
    end
    return {a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] a, b, c, d, input logic [511:0] msg);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.c_in = c; bus.d_in = d;
    bus.message = msg;
    bus.in_valid = 1'b1;
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a_in = $urandom; bus.b_in = $urandom; bus.c_in = $urandom; bus.d_in = $urandom;
    for (int j = 0; j < 16; j++) bus.message[32*j +: 32] = $urandom;
    check("ready_after_accept", 32'(bus.in_ready), (LAT == 1) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_result(input string tag, input logic [127:0] exp);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!bus.out_valid && n < 100);
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check({tag, "_a"}, bus.a_out, exp[127:96]);
    check({tag, "_b"}, bus.b_out, exp[95:64]);
    check({tag, "_c"}, bus.c_out, exp[63:32]);
    check({tag, "_d"}, bus.d_out, exp[31:0]);
  endtask

  task automatic consume();
    @(posedge clk);
    #1;
    check("consume_valid", 32'(bus.out_valid), 32'd0);
    check("consume_ready", 32'(bus.in_ready), 32'd1);
    check("consume_state", 32'(dbg_state), 32'(IDLE));
  endtask

  logic [511:0] msg_std;
  logic [511:0] msg_rnd;
  logic [127:0] exp_v;
  logic [31:0]  ra, rb, rc, rd;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.c_in = '0; bus.d_in = '0; bus.message = '0;
    for (int j = 0; j < 16; j++) msg_std[32*j +: 32] = MSG_W[j];

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_a", bus.a_out, 32'd0);
    check("rst_b", bus.b_out, 32'd0);
    check("rst_c", bus.c_out, 32'd0);
    check("rst_d", bus.d_out, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Single step from the standard IV
    st_a = 32'h67452301; st_b = 32'hefcdab89; st_c = 32'h98badcfe; st_d = 32'h10325476;
    st_m = 32'h6c6c6548; st_k = K_REF[0]; st_s = 5'd7;
    #1;
    check("step_iv_a", st_an, 32'h10325476);
    check("step_iv_b", st_bn, 32'hdb528b2a);
    check("step_iv_c", st_cn, 32'hefcdab89);
    check("step_iv_d", st_dn, 32'h98badcfe);

    // Single step from all-zero state and word
    st_a = '0; st_b = '0; st_c = '0; st_d = '0; st_m = '0;
    #1;
    check("step_zero_a", st_an, 32'h0);
    check("step_zero_b", st_bn, 32'hb5523c6b);
    check("step_zero_c", st_cn, 32'h0);
    check("step_zero_d", st_dn, 32'h0);

    // Full run with a held result
    exp_v = model(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, msg_std);
    start_job(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, msg_std);
    wait_result("full", exp_v);

    // Stall: out_ready low for 5 cycles while in_valid pushes junk
    @(negedge clk);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_ready", 32'(bus.in_ready), 32'd0);
      check("hold_a", bus.a_out, exp_v[127:96]);
      check("hold_b", bus.b_out, exp_v[95:64]);
      check("hold_c", bus.c_out, exp_v[63:32]);
      check("hold_d", bus.d_out, exp_v[31:0]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    consume();

    // Back-to-back jobs with out_ready held high
    exp_v = model(32'h0, 32'h0, 32'h0, 32'h0, '0);
    start_job(32'h0, 32'h0, 32'h0, 32'h0, '0);
    wait_result("zero", exp_v);
    consume();

    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    for (int j = 0; j < 16; j++) msg_rnd[32*j +: 32] = $urandom;
    exp_v = model(ra, rb, rc, rd, msg_rnd);
    start_job(ra, rb, rc, rd, msg_rnd);
    wait_result("rand", exp_v);
    consume();

    exp_v = model(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98, msg_std);
    start_job(32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfedcba98, msg_std);
    wait_result("iv2", exp_v);
    consume();

    // Reset in the middle of a job aborts it
    start_job(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, msg_std);
    for (int i = 0; i < MID_WAIT; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("midrst_a", bus.a_out, 32'd0);
    check("midrst_b", bus.b_out, 32'd0);
    check("midrst_c", bus.c_out, 32'd0);
    check("midrst_d", bus.d_out, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_output", 32'(bus.out_valid), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
